// File: rtl/iir_biquad_cascade.sv
// iir_biquad_cascade: NSEC direct-form-I biquads sharing one MAC, valid/ready on both ends.
// Define IIR_SAT_EN to clamp each section result; otherwise results wrap to DW bits.
module iir_biquad_cascade #(
   parameter int DW = 16,
   parameter int CW = 16,
   parameter int COEF_FRAC = 14,
   parameter int NSEC = 2
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [DW-1:0]               in_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [DW-1:0]               out_data,
   input  logic                        coef_we,
   input  logic [$clog2(5*NSEC)-1:0]   coef_addr,
   input  logic [CW-1:0]               coef_wdata
);
   localparam int NT = 5 * NSEC;
   localparam int AW = $clog2(NT);
   localparam int SW = NSEC > 1 ? $clog2(NSEC) : 1;
   localparam int ACCW = DW + CW + 4;
   localparam logic [AW-1:0] NTA = AW'(NT);
   localparam logic signed [CW-1:0] ONE = CW'(1 << COEF_FRAC);
   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
   state_t state, state_n;
   logic signed [CW-1:0] coef [NT];
   logic signed [DW-1:0] x1 [NSEC];
   logic signed [DW-1:0] x2 [NSEC];
   logic signed [DW-1:0] y1 [NSEC];
   logic signed [DW-1:0] y2 [NSEC];
   logic signed [DW-1:0] cur, opnd, y;
   logic signed [ACCW-1:0] acc, prod, acc_n;
   logic [AW-1:0] idx, pend_a;
   logic [2:0] tap;
   logic [SW-1:0] sec;
   logic last_sec, pend_v;
   logic signed [CW-1:0] pend_d;
   assign last_sec = sec == SW'(NSEC - 1);
   assign in_ready = state == IDLE && !rst;
   assign out_valid = state == DONE;
   always_comb begin
      opnd = tap == 3'd0 ? cur : tap == 3'd1 ? x1[sec] : tap == 3'd2 ? x2[sec] :
             tap == 3'd3 ? y1[sec] : y2[sec];
      prod = ACCW'(coef[idx]) * ACCW'(opnd);
      acc_n = tap >= 3'd3 ? acc - prod : acc + prod;
`ifdef IIR_SAT_EN
      y = (acc_n >>> COEF_FRAC) > ACCW'(2 ** (DW - 1) - 1) ? DW'(2 ** (DW - 1) - 1) :
          (acc_n >>> COEF_FRAC) < -ACCW'(2 ** (DW - 1)) ? DW'(2 ** (DW - 1)) :
          DW'(acc_n >>> COEF_FRAC);
`else
      y = DW'(acc_n >>> COEF_FRAC);
`endif
   end
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = in_valid ? MAC : IDLE;
         MAC:     state_n = (tap == 3'd4 && last_sec) ? DONE : MAC;
         DONE:    state_n = out_ready ? IDLE : DONE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) state <= rst ? IDLE : state_n;
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NT; i++) coef[i] <= (i % 5 == 0) ? ONE : '0;
         for (int i = 0; i < NSEC; i++) begin
            x1[i] <= '0;
            x2[i] <= '0;
            y1[i] <= '0;
            y2[i] <= '0;
         end
         cur <= '0;
         acc <= '0;
         idx <= '0;
         tap <= '0;
         sec <= '0;
         out_data <= '0;
         pend_v <= 1'b0;
         pend_a <= '0;
         pend_d <= '0;
      end else begin
         case (state)
            IDLE: begin
               // a write coinciding with a handshake is parked so this sample sees old coefficients
               if (coef_we && coef_addr < NTA) begin
                  if (in_valid) begin
                     pend_v <= 1'b1;
                     pend_a <= coef_addr;
                     pend_d <= coef_wdata;
                  end else coef[coef_addr] <= coef_wdata;
               end
               if (in_valid) begin
                  cur <= in_data;
                  acc <= '0;
                  idx <= '0;
                  tap <= '0;
                  sec <= '0;
               end
            end
            MAC: begin
               idx <= idx + 1'b1;
               if (tap == 3'd4) begin
                  tap <= '0;
                  sec <= sec + 1'b1;
                  acc <= '0;
                  cur <= y;
                  x2[sec] <= x1[sec];
                  x1[sec] <= cur;
                  y2[sec] <= y1[sec];
                  y1[sec] <= y;
                  if (last_sec) out_data <= y;
               end else begin
                  tap <= tap + 3'd1;
                  acc <= acc_n;
               end
            end
            DONE: begin
               if (out_ready && pend_v) begin
                  coef[pend_a] <= pend_d;
                  pend_v <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/iir_biquad_cascade.md
# iir_biquad_cascade

Parametrised successor to the single-section `iir_filter` biquad. It cascades NSEC direct-form-I biquad sections and time-multiplexes one multiplier-accumulator across all 5·NSEC coefficient taps. It adds valid/ready handshakes on input and output, plus a run-time coefficient write port. It sits between the sample source and the output sink in the filter datapath.

## Interface
- DW, 16, sample width (signed)
- CW, 16, coefficient width (signed)
- COEF_FRAC, 14, coefficient fractional bits (Q2.14 default, range ±2.0)
- NSEC, 2, number of cascaded biquad sections (≥1)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- in_data  in  DW  signed input sample
- out_valid  out  1  output sample valid
- out_ready  in  1  sink accepts output
- out_data  out  DW  signed filtered sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(5·NSEC)  section·5 + tap; tap 0=b0, 1=b1, 2=b2, 3=a1, 4=a2
- coef_wdata  in  CW  signed coefficient value

## Operation
- Per section: y = (b0·x + b1·x1 + b2·x2 − a1·y1 − a2·y2) >>> COEF_FRAC.
  - The shift is arithmetic; truncation rounds toward −∞.
  - Section s input is section s−1 output; section 0 input is in_data.
- Accumulator width DW+CW+4, signed. Products are sign-extended before accumulation.
- Section result reduction to DW bits: saturate or wrap (see Configuration). The reduced value feeds the next section and the y1 delay line.
- After a section's last tap: x2←x1, x1←x, y2←y1, y1←y for that section only.
- FSM states:
  - IDLE: in_ready=1. On in_valid && in_ready, latch in_data, clear acc, go to MAC at section 0 / tap 0.
  - MAC: one tap per cycle, tap 0..4 then next section. After section NSEC−1 tap 4, register out_data, go to DONE.
  - DONE: out_valid=1. On out_ready go to IDLE. out_data is held stable until then.
- Coefficient writes take effect only when coef_we is high in IDLE. Writes in MAC/DONE are ignored. coef_addr ≥ 5·NSEC is ignored.
- Reset values:
  - in_ready=0 during reset cycle, 1 after.
  - out_valid=0, out_data=0.
  - All delay lines 0, acc 0, FSM IDLE.
  - Coefficients: b0=1<<COEF_FRAC (1.0), all others 0, giving unity passthrough.
- rst asserted mid-MAC or in DONE aborts the sample, discards pending output, and applies all reset values. Coefficients also return to default.

## Timing
- Handshake accepted in cycle T → MAC occupies cycles T+1 … T+5·NSEC → out_valid high from cycle T+5·NSEC+1.
- Minimum input-to-output latency: 5·NSEC+1 cycles (11 at NSEC=2).
- in_ready is high only in IDLE. This gives a sample period of ≥5·NSEC+2 cycles; no input is accepted during MAC or DONE.
- On out_valid && out_ready in cycle U: out_valid=0 and in_ready=1 in cycle U+1.
- Simultaneous coef_we and input handshake in IDLE: the write completes, and the accepted sample uses the old coefficient. The new value applies from the next sample.
- in_valid with in_ready=0 is ignored; the source must hold it.

## Configuration
- IIR_SAT_EN defined:
  - Each section result is clamped to [−2^(DW−1), 2^(DW−1)−1] before feeding the next section and y1.
- IIR_SAT_EN undefined:
  - The low DW bits of the shifted accumulator are taken (two's-complement wrap).
  - No clamp logic is instantiated.

## Test plan
- Default coefficients after reset, NSEC=2:
  - Stimulus: in_data=1000.
  - Required response: out_data=1000, with out_valid exactly 11 cycles after the handshake.
- Coefficient load:
  - Stimulus: write addr 0 = 8192 (b0=0.5), then send 16384, 0, 0.
  - Required response: outputs 8192, 0, 0.
- Feedback:
  - Stimulus: sec0 a1=−8192 (y=x+0.5·y1); send impulse 1000, then four zeros.
  - Required response: outputs 1000, 500, 250, 125, 62.
- Overflow:
  - Stimulus: sec0 b0=32767; send x=30000.
  - Required response: with IIR_SAT_EN, out_data=32767; without it, out_data=−5538.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles, and pulse in_valid and coef_we during that time.
  - Required response: out_valid stays 1, out_data is unchanged, in_ready=0, and the write is ignored. The next output reflects the unchanged coefficients.
- Reset mid-MAC:
  - Stimulus: assert rst in cycle T+3 after a handshake.
  - Required response: no out_valid for the aborted sample; delay lines and coefficients return to default. The next sample 1000 yields 1000.
